// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: handshaked memory stage with byte-enable RAM, load FSM, fault detection and registered WB output
module mem_stage_pipe #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] MEM_BASE     = 32'h0,
    parameter int          MEM_DEPTH    = 1024,
    parameter int          READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_result,
    input  logic            in_rd_en,
    input  logic [4:0]      in_rd_addr,
    input  logic            in_load,
    input  logic            in_store,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [XLEN-1:0] in_store_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_rd_en,
    output logic [4:0]      out_rd_addr,
    output logic [XLEN-1:0] out_rd_data,
    output logic            out_fault,
    output logic [XLEN-1:0] out_fault_addr
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int AW   = $clog2(MEM_DEPTH);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] mem [MEM_DEPTH];
    logic [2:0]      counter;
    logic [XLEN-1:0] base, rel, wdata, word, sh, ld_data;
    logic            in_range, misalign, fault, accept, good_load, long_load, wait_done;
    logic [AW-1:0]   idx, s_idx, rd_idx;
    logic [OFFW-1:0] s_off, rd_off;
    logic [1:0]      s_size, rd_size;
    logic            s_uns, rd_uns, s_rd_en;
    logic [4:0]      s_rd_addr;
    logic [NB-1:0]   be;

    // Address decode, fault detection and store lane steering
    always_comb begin
        base      = XLEN'(MEM_BASE);
        rel       = in_result - base;
        in_range  = (in_result >= base) && (rel < XLEN'(MEM_DEPTH * NB));
        misalign  = (in_size == 2'd1 && in_result[0]) ||
                    (in_size == 2'd2 && in_result[1:0] != 2'd0) ||
                    (in_size == 2'd3 && (XLEN == 32 || in_result[2:0] != 3'd0));
        fault     = (in_load || in_store) && (!in_range || misalign);
        accept    = in_valid && in_ready;
        good_load = in_load && !fault;
        long_load = good_load && (READ_LATENCY > 1);
        wait_done = counter == 3'(READ_LATENCY - 1);
        idx       = rel[OFFW +: AW];
        be        = (in_size == 2'd0 ? NB'(1) : in_size == 2'd1 ? NB'(3) :
                     in_size == 2'd2 ? NB'(15) : NB'(255)) << in_result[OFFW-1:0];
        wdata     = in_size == 2'd0 ? {NB{in_store_data[7:0]}} :
                    in_size == 2'd1 ? {(NB/2){in_store_data[15:0]}} :
                    in_size == 2'd2 ? {(NB/4){in_store_data[31:0]}} : in_store_data;
    end

    // Load lane select and extension; a waiting load uses its captured address
    always_comb begin
        rd_idx  = state == LOAD_WAIT ? s_idx : idx;
        rd_off  = state == LOAD_WAIT ? s_off : in_result[OFFW-1:0];
        rd_size = state == LOAD_WAIT ? s_size : in_size;
        rd_uns  = state == LOAD_WAIT ? s_uns : in_unsigned;
        word    = mem[rd_idx];
        sh      = word >> {rd_off, 3'b000};
        ld_data = rd_size == 2'd0 ? (rd_uns ? XLEN'(sh[7:0]) : XLEN'($signed(sh[7:0]))) :
                  rd_size == 2'd1 ? (rd_uns ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]))) :
                  rd_size == 2'd2 ? (rd_uns ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]))) : sh;
    end

    // Data RAM write port: stores commit on their accept edge
    always_ff @(posedge clk) begin
        if (rst_n && accept && in_store && !fault)
            for (int b = 0; b < NB; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        if (state == IDLE && accept && long_load) state_nxt = LOAD_WAIT;
        if (state == LOAD_WAIT && wait_done)      state_nxt = IDLE;
    end

    // FSM outputs: accept only when idle and the WB register is free or draining
    always_comb begin
        in_ready = (state == IDLE) && (!out_valid || out_ready);
    end

    // Latency counter, captured load context and registered WB outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter        <= '0;
            s_idx          <= '0;
            s_off          <= '0;
            s_size         <= '0;
            s_uns          <= 1'b0;
            s_rd_en        <= 1'b0;
            s_rd_addr      <= '0;
            out_valid      <= 1'b0;
            out_rd_en      <= 1'b0;
            out_rd_addr    <= '0;
            out_rd_data    <= '0;
            out_fault      <= 1'b0;
            out_fault_addr <= '0;
        end else if (accept) begin
            counter   <= long_load ? 3'd1 : 3'd0;
            s_idx     <= idx;
            s_off     <= in_result[OFFW-1:0];
            s_size    <= in_size;
            s_uns     <= in_unsigned;
            s_rd_en   <= in_rd_en;
            s_rd_addr <= in_rd_addr;
            out_valid <= !long_load;
            if (!long_load) begin
                out_rd_en      <= in_rd_en && !fault;
                out_rd_addr    <= in_rd_addr;
                out_rd_data    <= fault ? '0 : in_load ? ld_data : in_result;
                out_fault      <= fault;
                out_fault_addr <= fault ? in_result : '0;
            end
        end else if (state == LOAD_WAIT) begin
            counter <= wait_done ? 3'd0 : counter + 3'd1;
            if (wait_done) begin
                out_valid      <= 1'b1;
                out_rd_en      <= s_rd_en;
                out_rd_addr    <= s_rd_addr;
                out_rd_data    <= ld_data;
                out_fault      <= 1'b0;
                out_fault_addr <= '0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: table-driven scoreboard bench plus latency, back-pressure and reset corner cases
module tb_mem_stage_pipe;
    localparam logic [31:0] BASE  = 32'h1000;
    localparam int          DEPTH = 16;

    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_ready, in_rd_en = 0, in_load = 0, in_store = 0, in_unsigned = 0;
    logic [31:0] in_result = 0, in_store_data = 0;
    logic [4:0]  in_rd_addr = 0;
    logic [1:0]  in_size = 0;
    logic        out_valid, out_ready = 1, out_rd_en, out_fault;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_rd_data, out_fault_addr;

    logic        rst3 = 0, v3 = 0, rdy3, ld3 = 0, st3 = 0, ov3, oen3, of3;
    logic [31:0] res3 = 0, sd3 = 0, od3, ofa3;
    logic [4:0]  ora3;

    int checks = 0, errors = 0;

    typedef struct {
        logic ld, st; logic [1:0] sz; logic uns;
        logic [31:0] addr, sd; logic rd_en; logic [4:0] rd;
        logic [31:0] ld_exp; logic flt;
    } vec_t;
    typedef struct {
        logic rd_en; logic [4:0] rd; logic [31:0] data; logic flt; logic [31:0] faddr;
    } exp_t;

    vec_t tbl[$];
    exp_t q[$];

    mem_stage_pipe #(.XLEN(32), .MEM_BASE(BASE), .MEM_DEPTH(DEPTH), .READ_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
        .in_load(in_load), .in_store(in_store), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_store_data(in_store_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd_en(out_rd_en),
        .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data),
        .out_fault(out_fault), .out_fault_addr(out_fault_addr));

    mem_stage_pipe #(.XLEN(32), .MEM_BASE(BASE), .MEM_DEPTH(DEPTH), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst3), .in_valid(v3), .in_ready(rdy3),
        .in_result(res3), .in_rd_en(1'b1), .in_rd_addr(5'd4),
        .in_load(ld3), .in_store(st3), .in_size(2'd2),
        .in_unsigned(1'b0), .in_store_data(sd3),
        .out_valid(ov3), .out_ready(1'b1), .out_rd_en(oen3),
        .out_rd_addr(ora3), .out_rd_data(od3),
        .out_fault(of3), .out_fault_addr(ofa3));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic [1:0] sz,
                                input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                                input logic rd_en, input logic [4:0] rd,
                                input logic [31:0] ld_exp, input logic flt);
        vec_t v;
        v.ld = ld; v.st = st; v.sz = sz; v.uns = uns; v.addr = addr; v.sd = sd;
        v.rd_en = rd_en; v.rd = rd; v.ld_exp = ld_exp; v.flt = flt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        int n;
        exp_t e;
        in_load = v.ld; in_store = v.st; in_size = v.sz; in_unsigned = v.uns;
        in_result = v.addr; in_store_data = v.sd; in_rd_en = v.rd_en; in_rd_addr = v.rd;
        in_valid = 1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout addr %h got in_ready 0 want 1", v.addr);
        end else begin
            e.rd_en = v.flt ? 1'b0 : v.rd_en;
            e.rd    = v.rd;
            e.data  = v.flt ? 32'h0 : v.ld ? v.ld_exp : v.addr;
            e.flt   = v.flt;
            e.faddr = v.flt ? v.addr : 32'h0;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    // Scoreboard: pop one expected record per WB handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected got data %h want none", out_rd_data);
            end else begin
                e = q.pop_front();
                chk("sb_rd_en", {31'b0, out_rd_en}, {31'b0, e.rd_en});
                chk("sb_rd_addr", {27'b0, out_rd_addr}, {27'b0, e.rd});
                chk("sb_rd_data", out_rd_data, e.data);
                chk("sb_fault", {31'b0, out_fault}, {31'b0, e.flt});
                chk("sb_fault_addr", out_fault_addr, e.faddr);
            end
        end
    end

    initial begin
        int n;
        // Load/store vectors on the latency-1 stage
        tbl.push_back(mk(0, 1, 2, 0, BASE + 4,  32'hDEADBEEF, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, BASE + 7,  0, 1, 5, 32'hFFFFFFDE, 0));
        tbl.push_back(mk(1, 0, 0, 1, BASE + 7,  0, 1, 6, 32'h000000DE, 0));
        tbl.push_back(mk(0, 1, 2, 0, BASE + 0,  32'h11223344, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, BASE + 2,  32'h00008001, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, BASE + 2,  0, 1, 1, 32'hFFFF8001, 0));
        tbl.push_back(mk(1, 0, 1, 1, BASE + 2,  0, 1, 2, 32'h00008001, 0));
        tbl.push_back(mk(1, 0, 2, 0, BASE + 0,  0, 1, 3, 32'h80013344, 0));
        tbl.push_back(mk(1, 0, 2, 0, BASE + 2,  0, 1, 8, 0, 1));
        tbl.push_back(mk(0, 1, 2, 0, BASE + 6,  32'h55555555, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 2, 0, BASE + 4,  0, 1, 9, 32'hDEADBEEF, 0));
        tbl.push_back(mk(1, 0, 2, 0, BASE + 64, 0, 1, 10, 0, 1));
        tbl.push_back(mk(1, 0, 2, 0, BASE - 4,  0, 1, 11, 0, 1));
        tbl.push_back(mk(1, 0, 3, 0, BASE + 0,  0, 1, 12, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, BASE + 3,  0, 1, 13, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h12345678, 0, 1, 7, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, BASE + 60, 32'h00000000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, BASE + 61, 32'h000000AB, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, BASE + 61, 0, 1, 14, 32'h000000AB, 0));
        tbl.push_back(mk(1, 0, 0, 0, BASE + 61, 0, 1, 15, 32'hFFFFFFAB, 0));
        tbl.push_back(mk(1, 0, 2, 0, BASE + 60, 0, 1, 16, 32'h0000AB00, 0));
        tbl.push_back(mk(1, 0, 1, 0, BASE + 60, 0, 1, 17, 32'hFFFFAB00, 0));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_rd_data", out_rd_data, 0);
        chk("rst_fault", {31'b0, out_fault}, 0);
        chk("rst3_out_valid", {31'b0, ov3}, 0);
        rst_n = 1; rst3 = 1;
        @(posedge clk); #1;
        chk("post_rst_rd_en", {31'b0, out_rd_en}, 0);
        chk("post_rst_fault_addr", out_fault_addr, 0);

        foreach (tbl[i]) drive(tbl[i]);

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("sb_drain", q.size(), 0);

        // Back-pressure: result held for 4 cycles, next op enters on release
        @(posedge clk); #1;
        out_ready = 0;
        drive(mk(0, 0, 0, 0, 32'hA1A1A1A1, 0, 1, 20, 0, 0));
        in_result = 32'hB2B2B2B2; in_rd_addr = 5'd21; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'b0, out_valid}, 1);
            chk("bp_rd_data", out_rd_data, 32'hA1A1A1A1);
            chk("bp_rd_addr", {27'b0, out_rd_addr}, 20);
            chk("bp_in_ready", {31'b0, in_ready}, 0);
            @(posedge clk); #1;
        end
        out_ready = 1;
        q.push_back('{rd_en: 1'b1, rd: 5'd21, data: 32'hB2B2B2B2, flt: 1'b0, faddr: 32'h0});
        @(negedge clk);
        chk("bp_release_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk("bp_next_data", out_rd_data, 32'hB2B2B2B2);
        @(posedge clk); #1;
        chk("bp_sb_drain", q.size(), 0);

        // Latency-3 stage: store, then load with wait cycles
        st3 = 1; res3 = BASE + 4; sd3 = 32'hCAFEF00D; v3 = 1;
        @(negedge clk);
        chk("l3_store_ready", {31'b0, rdy3}, 1);
        @(posedge clk); #1;
        v3 = 0; st3 = 0;
        @(negedge clk);
        chk("l3_store_valid", {31'b0, ov3}, 1);
        @(posedge clk); #1;
        ld3 = 1; v3 = 1;
        @(negedge clk);
        chk("l3_load_ready", {31'b0, rdy3}, 1);
        @(posedge clk); #1;
        v3 = 0; ld3 = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("l3_wait_valid", {31'b0, ov3}, 0);
            chk("l3_wait_ready", {31'b0, rdy3}, 0);
            @(posedge clk); #1;
        end
        chk("l3_done_valid", {31'b0, ov3}, 1);
        chk("l3_done_data", od3, 32'hCAFEF00D);
        chk("l3_done_rd", {27'b0, ora3}, 4);
        chk("l3_done_ready", {31'b0, rdy3}, 1);
        // Out-of-range load faults immediately even with a long read latency
        ld3 = 1; res3 = BASE + 64; v3 = 1;
        @(posedge clk); #1;
        v3 = 0; ld3 = 0;
        chk("l3_oor_valid", {31'b0, ov3}, 1);
        chk("l3_oor_fault", {31'b0, of3}, 1);
        chk("l3_oor_addr", ofa3, BASE + 64);
        chk("l3_oor_rd_en", {31'b0, oen3}, 0);
        // Reset in the middle of a load drops it
        @(posedge clk); #1;
        ld3 = 1; res3 = BASE + 4; v3 = 1;
        @(posedge clk); #1;
        v3 = 0; ld3 = 0;
        rst3 = 0;
        @(negedge clk);
        chk("l3_rst_valid", {31'b0, ov3}, 0);
        chk("l3_rst_ready", {31'b0, rdy3}, 1);
        rst3 = 1;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (ov3) n++;
        end
        chk("l3_rst_no_result", n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
